lut_init_seq: RTL and testbench
===============================

# lut_init_seq

Parametrised lookup table that fills itself at run time with the affine sequence value(a) = SCALE × (a + OFFSET), truncated to DATA_WIDTH. A sequencer performs the fill after reset and on demand. Once filled, the table serves registered reads and accepts single-entry overwrites. It replaces elaboration-time table initialisation wherever a design needs a resettable, re-initialisable, writable constant table.

## Interface

- DATA_WIDTH, 8, entry width in bits
- ADDR_WIDTH, 4, address width; DEPTH = 2**ADDR_WIDTH entries
- SCALE, 2, multiplier applied to (a + OFFSET); non-negative integer
- OFFSET, 2, added to the address before scaling; non-negative integer

- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- reinit  input  1  single-cycle request to refill the whole table from the sequence
- rd_en  input  1  read request
- rd_addr  input  ADDR_WIDTH  read address
- rd_data  output  DATA_WIDTH  read data, registered
- rd_valid  output  1  rd_data holds the result of an accepted read
- wr_en  input  1  write request
- wr_addr  input  ADDR_WIDTH  write address
- wr_data  input  DATA_WIDTH  write data
- ready  output  1  table is filled and accepting reads and writes

## Operation

- FSM has two states, INIT and READY. Reset forces INIT with init_cnt = 0.
- INIT:
  - Each cycle writes mem[init_cnt] = (SCALE × (init_cnt + OFFSET)) mod 2**DATA_WIDTH.
  - The product is computed at ≥ 32 bits, then the low DATA_WIDTH bits are kept.
  - init_cnt increments each cycle. When init_cnt == DEPTH-1, the FSM moves to READY and init_cnt wraps to 0.
  - rd_en, wr_en and reinit are ignored. No rd_valid is produced.
- READY:
  - rd_en = 1: rd_data <= mem[rd_addr], rd_valid <= 1.
  - rd_en = 0: rd_valid <= 0 and rd_data holds its value.
  - wr_en = 1: mem[wr_addr] <= wr_data.
  - reinit = 1: FSM returns to INIT with init_cnt = 0.
- Read and write in the same cycle to the same address: the read returns the old contents (read-before-write). The new value is visible on the next read.
- reinit together with wr_en in the same cycle: the write is dropped and reinit wins.
- reinit together with rd_en in the same cycle: the read is still serviced, with rd_valid = 1 next cycle, returning pre-refill data.
- Table contents are not reset. Only the FSM, init_cnt, rd_data, rd_valid and ready are reset.

## Timing

- Reset values: rd_data = 0, rd_valid = 0, ready = 0, state = INIT, init_cnt = 0.
- ready is registered and equals (state == READY). It rises after exactly DEPTH rising edges following reset release; default is 16.
- Read latency is 1 cycle. A read issued at edge N has rd_data and rd_valid valid after edge N+1.
- Reads may be issued back-to-back, one per cycle.
- Write latency is 1 cycle. A write at edge N is visible to a read issued at edge N+1.
- reinit pulse sampled at edge N: ready = 0 after edge N, and ready = 1 again after edge N+DEPTH.
- Reset asserted mid-INIT or mid-READY takes effect immediately and asynchronously. Outputs go to their reset values at once. After release the fill restarts from entry 0.
- Holding reinit high does not extend INIT, because it is only sampled in READY. Holding it high continuously re-enters INIT every DEPTH+1 cycles.

## Test plan

- Defaults, release rst_n → ready rises after exactly 16 edges; rd_valid stays 0 throughout even with rd_en held high.
- Default sequence: read addr 0 → 4; addr 5 → 14; addr 15 → 34. rd_valid = 1 one cycle after each rd_en.
- Write addr 5 ← 0xAA while reading addr 5 in the same cycle → returns 14; next read of addr 5 → 0xAA.
- reinit in READY with wr_en to addr 3 in the same cycle → write dropped; ready low for 16 cycles; then addr 3 → 10 and addr 5 → 14 (overwrite cleared).
- Assert rst_n low at INIT cycle 7 → outputs immediately reset; after release, full 16-cycle fill, then addr 7 → 18.
- DATA_WIDTH=4, SCALE=2, OFFSET=2 → addr 7 → 2 (18 mod 16), addr 15 → 2 (34 mod 16), addr 5 → 14.

Source files
------------

// File: rtl/lut_init_seq.sv
// lut_init_seq
//   Lookup table that fills itself with value(a) = SCALE * (a + OFFSET),
//   truncated to DATA_WIDTH. The fill runs after reset and again whenever
//   a refill is requested. Once the table is full it serves registered reads
//   and accepts single-entry overwrites.
//
// State table
//   state | meaning
//   INIT  | one entry per cycle is written from the sequence; reads, writes and reinit ignored
//   READY | table full; reads/writes serviced; reinit returns to INIT
//
// Ports
//   i_clk       clock, rising edge
//   i_rst_n     asynchronous active-low reset
//   i_reinit    single-cycle refill request (sampled in READY only)
//   i_rd_en     read request
//   i_rd_addr   read address
//   o_rd_data   registered read data
//   o_rd_valid  o_rd_data holds the result of an accepted read
//   i_wr_en     write request
//   i_wr_addr   write address
//   i_wr_data   write data
//   o_ready     table filled and accepting reads/writes
module lut_init_seq #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned SCALE      = 2,
    parameter int unsigned OFFSET     = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_reinit,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_rd_valid,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic                  o_ready
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_init_cnt;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
    logic [DATA_WIDTH-1:0]   r_rd_data;
    logic                    r_rd_valid;
    logic                    r_ready;

    logic                    w_init_we;
    logic                    w_rd_accept;
    logic                    w_wr_accept;
    logic [DATA_WIDTH-1:0]   w_fill_val;

    // Product formed at 32 bits, then truncated to the entry width.
    assign w_fill_val = DATA_WIDTH'(32'(SCALE) * (32'(r_init_cnt) + 32'(OFFSET)));

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            INIT: begin
                if (r_init_cnt == ADDR_WIDTH'(DEPTH - 1)) begin
                    w_state_nxt = READY;
                end
            end
            READY: begin
                if (i_reinit) begin
                    w_state_nxt = INIT;
                end
            end
            default: w_state_nxt = INIT;
        endcase
    end

    // Output / control decode
    always_comb begin
        w_init_we   = 1'b0;
        w_rd_accept = 1'b0;
        w_wr_accept = 1'b0;
        case (r_state)
            INIT: begin
                w_init_we = 1'b1;
            end
            READY: begin
                // A read in the reinit cycle is still serviced with pre-refill data;
                // a write in that cycle is dropped.
                w_rd_accept = i_rd_en;
                w_wr_accept = i_wr_en & ~i_reinit;
            end
            default: ;
        endcase
    end

    // Fill counter; wraps to 0 naturally on the last entry and is held at 0 in READY.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_init_cnt <= '0;
        end else if (w_init_we) begin
            r_init_cnt <= r_init_cnt + 1'b1;
        end else begin
            r_init_cnt <= '0;
        end
    end

    // Table storage is deliberately not reset; the fill sequence defines its contents.
    always_ff @(posedge i_clk) begin
        if (w_init_we) begin
            r_mem[r_init_cnt] <= w_fill_val;
        end else if (w_wr_accept) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Registered read port; non-blocking update gives read-before-write on collisions.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_ready    <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_accept;
            if (w_rd_accept) begin
                r_rd_data <= r_mem[i_rd_addr];
            end
            r_ready <= (w_state_nxt == READY);
        end
    end

    assign o_rd_data  = r_rd_data;
    assign o_rd_valid = r_rd_valid;
    assign o_ready    = r_ready;

endmodule

// File: tb/tb_lut_init_seq.sv
module tb_lut_init_seq;

    logic       clk;
    logic       rst_n;
    logic       reinit;
    logic       rd_en;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       ready;

    // Narrow instance: DATA_WIDTH=4 exercises truncation.
    logic       n_rd_en;
    logic [3:0] n_rd_addr;
    logic [3:0] n_rd_data;
    logic       n_rd_valid;
    logic       n_ready;
    logic       n_reinit;
    logic       n_wr_en;
    logic [3:0] n_wr_addr;
    logic [3:0] n_wr_data;

    int n_cmp;
    int n_err;

    lut_init_seq #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .SCALE(2), .OFFSET(2)) u_dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_reinit   (reinit),
        .i_rd_en    (rd_en),
        .i_rd_addr  (rd_addr),
        .o_rd_data  (rd_data),
        .o_rd_valid (rd_valid),
        .i_wr_en    (wr_en),
        .i_wr_addr  (wr_addr),
        .i_wr_data  (wr_data),
        .o_ready    (ready)
    );

    lut_init_seq #(.DATA_WIDTH(4), .ADDR_WIDTH(4), .SCALE(2), .OFFSET(2)) u_dut_n (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_reinit   (n_reinit),
        .i_rd_en    (n_rd_en),
        .i_rd_addr  (n_rd_addr),
        .o_rd_data  (n_rd_data),
        .o_rd_valid (n_rd_valid),
        .i_wr_en    (n_wr_en),
        .i_wr_addr  (n_wr_addr),
        .i_wr_data  (n_wr_data),
        .o_ready    (n_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one read on the wide instance and check the registered result.
    task automatic rd_chk(input string tag, input logic [3:0] a, input logic [7:0] exp);
        rd_en   = 1'b1;
        rd_addr = a;
        step();
        rd_en = 1'b0;
        chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
        chk({tag, "_data"}, 32'(rd_data), 32'(exp));
    endtask

    task automatic n_rd_chk(input string tag, input logic [3:0] a, input logic [3:0] exp);
        n_rd_en   = 1'b1;
        n_rd_addr = a;
        step();
        n_rd_en = 1'b0;
        chk({tag, "_valid"}, 32'(n_rd_valid), 32'd1);
        chk({tag, "_data"}, 32'(n_rd_data), 32'(exp));
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        reinit    = 1'b0;
        rd_en     = 1'b1;
        rd_addr   = 4'd0;
        wr_en     = 1'b0;
        wr_addr   = 4'd0;
        wr_data   = 8'd0;
        n_rd_en   = 1'b0;
        n_rd_addr = 4'd0;
        n_reinit  = 1'b0;
        n_wr_en   = 1'b0;
        n_wr_addr = 4'd0;
        n_wr_data = 4'd0;

        #2;
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_valid", 32'(rd_valid), 32'd0);
        chk("rst_data", 32'(rd_data), 32'd0);
        step();
        step();
        rst_n = 1'b1;

        // Fill: ready after exactly 16 edges, no rd_valid despite rd_en held high.
        for (int i = 1; i <= 16; i++) begin
            step();
            chk($sformatf("fill_ready_%0d", i), 32'(ready), 32'(i == 16));
            chk($sformatf("fill_valid_%0d", i), 32'(rd_valid), 32'd0);
        end
        rd_en = 1'b0;

        rd_chk("rd0", 4'd0, 8'd4);
        rd_chk("rd5", 4'd5, 8'd14);
        rd_chk("rd15", 4'd15, 8'd34);
        step();
        chk("idle_valid", 32'(rd_valid), 32'd0);
        chk("idle_hold", 32'(rd_data), 32'd34);

        // Same-address read and write: old contents returned, new value next.
        wr_en   = 1'b1;
        wr_addr = 4'd5;
        wr_data = 8'hAA;
        rd_chk("rbw_old", 4'd5, 8'd14);
        wr_en = 1'b0;
        rd_chk("rbw_new", 4'd5, 8'hAA);

        // reinit with a write (dropped) and a read (serviced with pre-refill data).
        reinit  = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 4'd3;
        wr_data = 8'h55;
        rd_en   = 1'b1;
        rd_addr = 4'd5;
        step();
        reinit = 1'b0;
        wr_en  = 1'b0;
        rd_en  = 1'b0;
        chk("reinit_ready", 32'(ready), 32'd0);
        chk("reinit_rd_valid", 32'(rd_valid), 32'd1);
        chk("reinit_rd_data", 32'(rd_data), 32'hAA);
        for (int i = 1; i <= 16; i++) begin
            step();
            chk($sformatf("refill_ready_%0d", i), 32'(ready), 32'(i == 16));
        end
        rd_chk("refill3", 4'd3, 8'd10);
        rd_chk("refill5", 4'd5, 8'd14);

        // Asynchronous reset in the middle of a fill.
        reinit = 1'b1;
        step();
        reinit = 1'b0;
        for (int i = 0; i < 7; i++) step();
        chk("mid_init_ready", 32'(ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_ready", 32'(ready), 32'd0);
        chk("async_valid", 32'(rd_valid), 32'd0);
        chk("async_data", 32'(rd_data), 32'd0);
        step();
        rst_n = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step();
            chk($sformatf("rst_fill_ready_%0d", i), 32'(ready), 32'(i == 16));
        end
        rd_chk("after_rst7", 4'd7, 8'd18);

        // Narrow instance was refilled after the same reset release.
        chk("n_ready", 32'(n_ready), 32'd1);
        n_rd_chk("n_rd7", 4'd7, 4'd2);
        n_rd_chk("n_rd15", 4'd15, 4'd2);
        n_rd_chk("n_rd5", 4'd5, 4'd14);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
